// File: rtl/constants.sv
// Shared synth constants: phase accumulator width, sample divider and waveform encoding.
package constants;

    localparam int SYNTH_PHASE_ACC_BITS = 24;
    localparam int SYNTH_SAMPLE_DIV     = 512;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_sel_t;

endpackage

// File: rtl/synth_wave_shaper.sv
// Combinational waveform shaper: maps the top 17 phase bits and a waveform select
// to a 16-bit two's-complement sample.
module synth_wave_shaper
    import constants::*;
(
    input  logic [16:0] i_phase_top,
    input  wave_sel_t   i_wave_sel,
    output logic [15:0] o_sample
);

    logic [15:0] w_tri;

    // Fold the upper half of the cycle to get a symmetric triangle ramp.
    always_comb begin
        w_tri = 16'h0000;
        if (i_phase_top[16]) begin
            w_tri = ~i_phase_top[15:0];
        end else begin
            w_tri = i_phase_top[15:0];
        end
    end

    // Waveform selection; the MSB flip converts offset-binary ramps to signed.
    always_comb begin
        o_sample = 16'h0000;
        case (i_wave_sel)
            WAVE_SAW:    o_sample = i_phase_top[16:1] ^ 16'h8000;
            WAVE_SQUARE: o_sample = i_phase_top[16] ? 16'h8000 : 16'h7FFF;
            WAVE_TRI:    o_sample = w_tri ^ 16'h8000;
            WAVE_OFF:    o_sample = 16'h0000;
            default:     o_sample = 16'h0000;
        endcase
    end

endmodule

// File: rtl/synth_oscillator.sv
// Phase-accumulator oscillator: one sample per SAMPLE_DIV clocks with a valid strobe.
// Optional increment glide between nonzero notes is compiled in with SYNTH_GLIDE_EN.
module synth_oscillator
    import constants::*;
#(
    parameter int          PHASE_BITS  = SYNTH_PHASE_ACC_BITS,
    parameter int          SAMPLE_BITS = 16,
    parameter int          SAMPLE_DIV  = SYNTH_SAMPLE_DIV,
    parameter int unsigned GLIDE_STEP  = 32'h0000_0100
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [PHASE_BITS-1:0]         phase_incr_in,
    input  logic [1:0]                    wave_sel_in,
    output logic signed [SAMPLE_BITS-1:0] sample_out,
    output logic                          sample_valid_out,
    output logic                          note_active_out
);

    localparam int                    DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [PHASE_BITS-1:0] PH_ZERO  = {PHASE_BITS{1'b0}};
    localparam logic [PHASE_BITS-1:0] STEP     = PHASE_BITS'(GLIDE_STEP);

    logic [DIV_W-1:0]      r_div;
    logic                  w_tick;
    logic                  r_tick_d;
    logic [PHASE_BITS-1:0] r_phase;
    logic [PHASE_BITS-1:0] r_incr;
    logic [PHASE_BITS-1:0] w_incr_next;
    logic [15:0]           w_sample;
    wave_sel_t             w_wave_sel;

    // Move cur toward tgt by at most STEP, landing exactly on tgt.
    function automatic logic [PHASE_BITS-1:0] glide_next(
        input logic [PHASE_BITS-1:0] cur,
        input logic [PHASE_BITS-1:0] tgt
    );
        logic [PHASE_BITS-1:0] res;
        if (tgt > cur) begin
            res = ((tgt - cur) > STEP) ? (cur + STEP) : tgt;
        end else begin
            res = ((cur - tgt) > STEP) ? (cur - STEP) : tgt;
        end
        return res;
    endfunction

    assign w_tick     = (r_div == DIV_LAST);
    assign w_wave_sel = wave_sel_t'(wave_sel_in);

    // Sample-period divider.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_div <= {DIV_W{1'b0}};
        end else if (w_tick) begin
            r_div <= {DIV_W{1'b0}};
        end else begin
            r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Increment applied at the next tick: note off, jump, or glide.
    always_comb begin
        w_incr_next = PH_ZERO;
        if (phase_incr_in == PH_ZERO) begin
            w_incr_next = PH_ZERO;
        end else begin
`ifdef SYNTH_GLIDE_EN
            if (r_incr == PH_ZERO) begin
                w_incr_next = phase_incr_in;
            end else begin
                w_incr_next = glide_next(r_incr, phase_incr_in);
            end
`else
            w_incr_next = phase_incr_in;
`endif
        end
    end

    // Stage 1: phase accumulation on tick edges; note off also clears the phase.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_incr  <= PH_ZERO;
            r_phase <= PH_ZERO;
        end else if (w_tick) begin
            r_incr  <= w_incr_next;
            r_phase <= (phase_incr_in == PH_ZERO) ? PH_ZERO : (r_phase + w_incr_next);
        end else begin
            r_incr  <= r_incr;
            r_phase <= r_phase;
        end
    end

    synth_wave_shaper u_shaper (
        .i_phase_top (r_phase[PHASE_BITS-1 -: 17]),
        .i_wave_sel  (w_wave_sel),
        .o_sample    (w_sample)
    );

    // Stage 2: register the shaped sample one edge after the tick.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tick_d         <= 1'b0;
            sample_valid_out <= 1'b0;
            note_active_out  <= 1'b0;
            sample_out       <= '0;
        end else begin
            r_tick_d <= w_tick;
            if (r_tick_d) begin
                sample_valid_out <= 1'b1;
                note_active_out  <= (r_incr != PH_ZERO);
                sample_out       <= (r_incr == PH_ZERO) ? '0 : $signed(w_sample);
            end else begin
                sample_valid_out <= 1'b0;
                note_active_out  <= note_active_out;
                sample_out       <= sample_out;
            end
        end
    end

endmodule

// File: tb/tb_synth_oscillator.sv
// Scoreboard bench for synth_oscillator with SAMPLE_DIV = 4; glide scenario under SYNTH_GLIDE_EN.
module tb_synth_oscillator;

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic [23:0]        phase_incr_in;
    logic [1:0]         wave_sel_in;
    logic signed [15:0] sample_out;
    logic               sample_valid_out;
    logic               note_active_out;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_pulse = 0;

    typedef struct {
        logic [15:0] s;
        logic        a;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] m_phase;
    logic [23:0] m_incr;

    synth_oscillator #(.SAMPLE_DIV(4)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .phase_incr_in    (phase_incr_in),
        .wave_sel_in      (wave_sel_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .note_active_out  (note_active_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [15:0] m_shape(input logic [23:0] ph, input logic [1:0] ws,
                                            input logic [23:0] inc);
        logic [15:0] t;
        if (inc == 24'h0 || ws == 2'd3) return 16'h0000;
        if (ws == 2'd0) return ph[23:8] ^ 16'h8000;
        if (ws == 2'd1) return ph[23] ? 16'h8000 : 16'h7FFF;
        t = ph[23] ? ~ph[22:7] : ph[22:7];
        return t ^ 16'h8000;
    endfunction

    // Reference model of one tick plus stage-2 shaping; pushes the expected result.
    task automatic push_period(input logic [23:0] inc, input logic [1:0] ws);
        exp_t e;
        if (inc == 24'h0) begin
            m_incr = 24'h0;
        end else begin
`ifdef SYNTH_GLIDE_EN
            if (m_incr == 24'h0) m_incr = inc;
            else if (inc > m_incr) m_incr = ((inc - m_incr) > 24'h100) ? m_incr + 24'h100 : inc;
            else m_incr = ((m_incr - inc) > 24'h100) ? m_incr - 24'h100 : inc;
`else
            m_incr = inc;
`endif
        end
        m_phase = (inc == 24'h0) ? 24'h0 : m_phase + m_incr;
        e.s = m_shape(m_phase, ws, m_incr);
        e.a = (m_incr != 24'h0);
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next valid pulse, then check timing and pop/compare.
    task automatic wait_pulse(input string name, input bit from_release);
        int   k;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (k = 1; k <= 16; k++) begin
            @(negedge clk_in);
            if (sample_valid_out) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s timeout: no valid pulse within 16 cycles (required one)", name);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (from_release) begin
            if (k !== 5) begin
                n_bad++;
                $display("FAIL %s first-pulse latency: got %0d cycles, expected 5", name, k);
            end
        end else begin
            if ((cyc - last_pulse) !== 4) begin
                n_bad++;
                $display("FAIL %s pulse gap: got %0d cycles, expected 4", name, cyc - last_pulse);
            end
        end
        last_pulse = cyc;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard empty: got a pulse, expected none", name);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if ($unsigned(sample_out) !== e.s) begin
            n_bad++;
            $display("FAIL %s sample: got %h, expected %h", name, sample_out, e.s);
        end
        n_vec++;
        if (note_active_out !== e.a) begin
            n_bad++;
            $display("FAIL %s note_active: got %b, expected %b", name, note_active_out, e.a);
        end
        @(negedge clk_in);
        n_vec++;
        if (sample_valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s valid width: got %b one cycle later, expected 0", name, sample_valid_out);
        end
    endtask

    task automatic period(input logic [23:0] inc, input logic [1:0] ws, input string name);
        phase_incr_in = inc;
        wave_sel_in   = ws;
        push_period(inc, ws);
        wait_pulse(name, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if (sample_out !== 16'sh0000 || sample_valid_out !== 1'b0 || note_active_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s outputs: got sample=%h valid=%b active=%b, expected 0/0/0",
                     name, sample_out, sample_valid_out, note_active_out);
        end
    endtask

    task automatic release_first(input logic [23:0] inc, input logic [1:0] ws, input string name);
        m_phase = 24'h0;
        m_incr  = 24'h0;
        sb.delete();
        phase_incr_in = inc;
        wave_sel_in   = ws;
        push_period(inc, ws);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        wait_pulse(name, 1'b1);
    endtask

    task automatic test_reset_a4_saw();
        rst_n_in      = 1'b0;
        phase_incr_in = 24'h009630;
        wave_sel_in   = 2'd0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset_state");
        release_first(24'h009630, 2'd0, "a4_saw_first");
        period(24'h009630, 2'd0, "a4_saw_second");
        period(24'h009630, 2'd0, "a4_saw_third");
    endtask

    task automatic test_note_off();
        period(24'h000000, 2'd0, "note_off");
        period(24'h009630, 2'd0, "note_restart");
    endtask

    task automatic test_wrap_square();
        period(24'h000000, 2'd1, "square_clear");
        for (int i = 0; i < 3; i++) period(24'h800000, 2'd1, "square_wrap");
    endtask

    task automatic test_triangle_off();
        period(24'h000000, 2'd2, "tri_clear");
        for (int i = 0; i < 8; i++) period(24'h200000, 2'd2, "triangle");
        period(24'h050123, 2'd2, "triangle_odd");
        period(24'h200000, 2'd3, "select_off");
        period(24'h123456, 2'd0, "saw_odd");
    endtask

    task automatic test_ignore_between_ticks();
        phase_incr_in = 24'hFFFFFF;
        wave_sel_in   = 2'd3;
        @(negedge clk_in);
        period(24'h009630, 2'd0, "glitch_ignored");
    endtask

    task automatic test_reset_mid_period();
        phase_incr_in = 24'h009630;
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        release_first(24'h009630, 2'd0, "after_reset");
        period(24'h009630, 2'd0, "after_reset_next");
    endtask

    task automatic test_glide();
`ifdef SYNTH_GLIDE_EN
        period(24'h000000, 2'd0, "glide_clear");
        period(24'h009630, 2'd0, "glide_jump");
        for (int i = 0; i < 21; i++) period(24'h00A894, 2'd0, "glide_up");
        for (int i = 0; i < 21; i++) period(24'h009630, 2'd0, "glide_down");
        period(24'h000000, 2'd0, "glide_off");
`endif
    endtask

    initial begin
        m_phase = 24'h0;
        m_incr  = 24'h0;
        test_reset_a4_saw();
        test_note_off();
        test_wrap_square();
        test_triangle_off();
        test_ignore_between_ticks();
        test_reset_mid_period();
        test_glide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
